// File: rtl/alu_control_seq_if.sv
// Request/response bundle between the decode stage (master) and the ALU control unit (slave).
// Carries the request handshake, the decoded-result handshake, flush and the busy indication.
interface alu_control_seq_if #(
  parameter int FUNCT_W = 6
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         ALUOp;
  logic [FUNCT_W-1:0] funct_ctrl;
  logic               out_valid;
  logic               out_ready;
  logic [FUNCT_W-1:0] funct;
  logic               illegal;
  logic               busy;

  modport master (
    output flush, in_valid, ALUOp, funct_ctrl, out_ready,
    input  in_ready, out_valid, funct, illegal, busy
  );

  modport slave (
    input  flush, in_valid, ALUOp, funct_ctrl, out_ready,
    output in_ready, out_valid, funct, illegal, busy
  );
endinterface

// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU control: decodes ALUOp/funct_ctrl and sequences fixed-latency MULTU/DIVU.
// Define ALU_MULDIV_EN to enable the multi-cycle ops (BUSY state and latency counter).
module alu_control_seq #(
  parameter int FUNCT_W = 6,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_control_seq_if.slave bus
);

  // A misconfigured instance never accepts work instead of producing garbage.
  localparam bit PARAMS_OK = (FUNCT_W >= 6) && (MUL_LAT >= 1) && (DIV_LAT >= 1);

  localparam logic [FUNCT_W-1:0] FC_ADDU  = FUNCT_W'(6'b001011);
  localparam logic [FUNCT_W-1:0] FC_SUBU  = FUNCT_W'(6'b001101);
  localparam logic [FUNCT_W-1:0] FC_NOR   = FUNCT_W'(6'b100111);
  localparam logic [FUNCT_W-1:0] FC_SLTU  = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] ALU_ADDU = FUNCT_W'(6'b001001);
  localparam logic [FUNCT_W-1:0] ALU_SUBU = FUNCT_W'(6'b001010);
  localparam logic [FUNCT_W-1:0] ALU_NOR  = FUNCT_W'(6'b010011);
  localparam logic [FUNCT_W-1:0] ALU_SLTU = FUNCT_W'(6'b101010);

`ifdef ALU_MULDIV_EN
  localparam logic [FUNCT_W-1:0] FC_MULTU  = FUNCT_W'(6'b011001);
  localparam logic [FUNCT_W-1:0] FC_DIVU   = FUNCT_W'(6'b011011);
  localparam logic [FUNCT_W-1:0] ALU_MULTU = FUNCT_W'(6'b011001);
  localparam logic [FUNCT_W-1:0] ALU_DIVU  = FUNCT_W'(6'b011011);
  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1
`ifdef ALU_MULDIV_EN
    ,
    BUSY = 2'd2
`endif
  } state_t;

  state_t             state_reg;
  logic [FUNCT_W-1:0] funct_reg;
  logic               illegal_reg;
  logic               out_valid_reg;
`ifdef ALU_MULDIV_EN
  logic               busy_reg;
  logic [CNT_W-1:0]   cnt_reg;
`endif

  logic [FUNCT_W-1:0] dec_funct;
  logic               dec_illegal;
`ifdef ALU_MULDIV_EN
  logic               dec_multi;
  logic [CNT_W-1:0]   dec_cnt;
`endif
  logic               can_accept;
  logic               accept;

  always_comb begin
    dec_funct   = '0;
    dec_illegal = 1'b1;
`ifdef ALU_MULDIV_EN
    dec_multi   = 1'b0;
    dec_cnt     = '0;
`endif
    case (bus.ALUOp)
      2'b00: begin
        dec_funct   = ALU_ADDU;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_funct   = ALU_SUBU;
        dec_illegal = 1'b0;
      end
      2'b10: begin
        case (bus.funct_ctrl)
          FC_ADDU: begin
            dec_funct   = ALU_ADDU;
            dec_illegal = 1'b0;
          end
          FC_SUBU: begin
            dec_funct   = ALU_SUBU;
            dec_illegal = 1'b0;
          end
          FC_NOR: begin
            dec_funct   = ALU_NOR;
            dec_illegal = 1'b0;
          end
          FC_SLTU: begin
            dec_funct   = ALU_SLTU;
            dec_illegal = 1'b0;
          end
`ifdef ALU_MULDIV_EN
          FC_MULTU: begin
            dec_funct   = ALU_MULTU;
            dec_illegal = 1'b0;
            dec_multi   = 1'b1;
            dec_cnt     = CNT_W'(MUL_LAT - 1);
          end
          FC_DIVU: begin
            dec_funct   = ALU_DIVU;
            dec_illegal = 1'b0;
            dec_multi   = 1'b1;
            dec_cnt     = CNT_W'(DIV_LAT - 1);
          end
`endif
          default: begin
            dec_funct   = '0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_funct   = '0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // A new request may enter in the same cycle the held result is consumed.
  assign can_accept   = (state_reg == IDLE) || ((state_reg == OUT) && bus.out_ready);
  assign bus.in_ready = PARAMS_OK && !bus.flush && can_accept;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      funct_reg     <= '0;
      illegal_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
`ifdef ALU_MULDIV_EN
      busy_reg      <= 1'b0;
      cnt_reg       <= '0;
`endif
    end else if (bus.flush) begin
      state_reg     <= IDLE;
      funct_reg     <= '0;
      illegal_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
`ifdef ALU_MULDIV_EN
      busy_reg      <= 1'b0;
      cnt_reg       <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: ;
        OUT: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
`ifdef ALU_MULDIV_EN
        BUSY: begin
          if (cnt_reg == '0) begin
            state_reg     <= OUT;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
`endif
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase

      // Accept overrides the consume-to-IDLE transition above.
      if (accept) begin
        funct_reg   <= dec_funct;
        illegal_reg <= dec_illegal;
`ifdef ALU_MULDIV_EN
        if (dec_multi) begin
          state_reg     <= BUSY;
          busy_reg      <= 1'b1;
          out_valid_reg <= 1'b0;
          cnt_reg       <= dec_cnt;
        end else begin
          state_reg     <= OUT;
          out_valid_reg <= 1'b1;
        end
`else
        state_reg     <= OUT;
        out_valid_reg <= 1'b1;
`endif
      end
    end
  end

  assign bus.funct     = funct_reg;
  assign bus.illegal   = illegal_reg;
  assign bus.out_valid = out_valid_reg;
`ifdef ALU_MULDIV_EN
  assign bus.busy      = busy_reg;
`else
  assign bus.busy      = 1'b0;
`endif

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, handshaked ALU control unit for the multi-cycle datapath. It decodes `ALUOp`/`funct_ctrl` into the 6-bit ALU function code and holds each decoded operation until the ALU accepts it. It also sequences fixed-latency multi-cycle operations (MULTU/DIVU), so the controller sees `busy` while they run. It sits between the main control/decode stage and the ALU, replacing the purely combinational ALU control.

## Interface
Parameters:
- `FUNCT_W`, 6: width of `funct_ctrl` and `funct`. Must be ≥ 6; codes below are zero-extended.
- `MUL_LAT`, 4: cycles spent in BUSY for MULTU. Must be ≥ 1.
- `DIV_LAT`, 8: cycles spent in BUSY for DIVU. Must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept a request this cycle.
- `ALUOp`  in  2  main-control operation class.
- `funct_ctrl`  in  FUNCT_W  instruction function field.
- `out_valid`  out  1  `funct` and `illegal` are valid.
- `out_ready`  in  1  ALU consumes the output this cycle.
- `funct`  out  FUNCT_W  registered ALU function code.
- `illegal`  out  1  the presented operation did not decode; `funct`=0.
- `busy`  out  1  multi-cycle operation in progress.

## Operation
- Decode when `ALUOp` is 00: Addu 001001.
- Decode when `ALUOp` is 01: Subu 001010.
- Decode when `ALUOp` is 10, by `funct_ctrl`:
  - 001011 → 001001 (Addu)
  - 001101 → 001010 (Subu)
  - 100111 → 010011 (Nor)
  - 101010 → 101010 (Sltu)
  - 011001 → 011001 (Multu, multi-cycle, MUL_LAT)
  - 011011 → 011011 (Divu, multi-cycle, DIV_LAT)
  - any other value → `funct`=0, `illegal`=1.
- Decode when `ALUOp` is 11: `funct`=0, `illegal`=1.
- Accept condition: `in_valid && in_ready`. Decoded `funct`/`illegal` are captured into registers on accept.
- FSM states:
  - IDLE: `in_ready`=1. On accept of a single-cycle or illegal op → OUT. On accept of a multi-cycle op → BUSY, with `cnt` loaded to LAT-1.
  - BUSY: `busy`=1, `in_ready`=0, `cnt` decrements each cycle. When `cnt`==0 → OUT.
  - OUT: `out_valid`=1, outputs held stable until `out_ready`. `in_ready`=`out_ready`, so back-to-back accept is allowed in the cycle the output is consumed. On consume with no accept → IDLE. On consume with accept → OUT or BUSY per the new op.
- `cnt` width is `$clog2(max(MUL_LAT,DIV_LAT))`, minimum 1. `cnt` never wraps below 0.
- `flush` (priority below reset, above everything else):
  - Next state IDLE, `out_valid`/`busy`/`illegal` cleared, `funct` cleared.
  - Any request presented in the same cycle is not accepted; `in_ready`=0 while `flush`=1.
- Reset: state IDLE, `funct`=0, `out_valid`=0, `illegal`=0, `busy`=0, `cnt`=0. Reset mid-BUSY or mid-OUT drops the operation and produces no output.

## Timing
- Single-cycle op accepted at edge T: `out_valid`=1 from T+1.
- Multi-cycle op accepted at T:
  - `busy`=1 for cycles T+1 … T+LAT.
  - `out_valid`=1 from T+LAT+1.
- Output hold: `funct` and `illegal` do not change while `out_valid`=1 and `out_ready`=0.
- Throughput: one single-cycle op per clock when `out_ready` stays high.
- `busy` and `out_valid` are never high together.
- All outputs come from registers except `in_ready`, which is combinational from state, `out_ready` and `flush`.

## Configuration
- Macro `ALU_MULDIV_EN`.
- Defined: Multu/Divu decode as above; BUSY state and `cnt` are present.
- Undefined:
  - 011001 and 011011 decode as illegal.
  - BUSY state and `cnt` are removed; `busy` is tied to 0.
  - `MUL_LAT`/`DIV_LAT` are ignored.
  - All other behaviour is identical.

## Test plan
- Reset, then `ALUOp`=00 accepted with `out_ready`=1 → next cycle `out_valid`=1, `funct`=001001, `illegal`=0; `ALUOp`=01 back-to-back → `funct`=001010 on the following cycle.
- `ALUOp`=10, `funct_ctrl`=100111 with `out_ready`=0 for 3 cycles → `funct`=010011 held stable, `in_ready`=0 throughout; consumed on the 4th cycle.
- `ALUOp`=11, then `ALUOp`=10/`funct_ctrl`=000111 → each gives `funct`=0, `illegal`=1, handshake completes normally.
- With `ALU_MULDIV_EN` defined and `MUL_LAT`=4: `funct_ctrl`=011001 accepted at T → `busy` high T+1..T+4, `out_valid` with `funct`=011001 at T+5. Without the macro, the same stimulus → `illegal`=1 at T+1 and `busy` never asserts.
- With `DIV_LAT`=8, Divu accepted, `flush` at BUSY cycle 3 → `busy` and `out_valid` 0 next cycle, no output; a simultaneous `in_valid` is not accepted. Repeat with `rst_n`=0 mid-BUSY → all outputs at reset values.
